x25519_byte_frontend: RTL and testbench
=======================================

# x25519_byte_frontend

Byte-stream front end for the `curve25519` scalar-multiplication core. It accepts a 64-byte job (32-byte scalar, then 32-byte u-coordinate, both little-endian), applies RFC 7748 scalar clamping and u-coordinate masking, and launches the core with a one-cycle start pulse. It then captures the core result and streams it out as 32 little-endian bytes. It sits directly upstream and downstream of the core, between the core and any byte-oriented transport.

## Interface
- `CLAMP`, default 1: when 1, apply RFC 7748 clamping to the scalar; when 0, pass scalar bits [254:0] unmodified.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  job byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `out_data`  out  8  result byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts a byte; transfer occurs when `out_valid && out_ready` at a rising edge.
- `out_last`  out  1  high with the 32nd result byte.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_n`  out  255  clamped scalar.
- `core_q`  out  255  masked u-coordinate.
- `core_done`  in  1  core result valid (pulse).
- `core_out`  in  255  core result.
- `busy`  out  1  high in START and WAIT.

## Operation
- **States and transitions:**
  - IDLE → LOAD unconditionally.
  - LOAD → START after the 64th accepted byte.
  - START → WAIT (always exactly one cycle).
  - WAIT → SEND on `core_done`.
  - SEND → LOAD after the 32nd byte transfer.
- **LOAD:**
  - `in_ready=1`.
  - A 6-bit byte counter indexes the bytes.
  - Bytes 0–31 fill scalar register bits [8i+7:8i].
  - Bytes 32–63 fill the u register likewise.
- **Clamping (CLAMP=1):**
  - `core_n` = scalar[254:0] with bits [2:0] forced 0 and bit 254 forced 1.
  - Scalar bit 255 is discarded.
- **Masking:**
  - `core_q` = u[254:0]; u bit 255 is discarded.
  - No reduction mod p; non-canonical u is passed unchanged.
- **Core inputs:** `core_n` and `core_q` are registered and held stable from START until the next LOAD completes.
- **START:** `core_start=1` for exactly one cycle.
- **WAIT:**
  - On `core_done=1`, latch `core_out` into the 255-bit result register, with bit 255 set to 0.
  - `core_done` is ignored in every state except WAIT.
- **SEND:**
  - Byte j = result[8j+7:8j], for j = 0..31, in order.
  - `out_last` is high only for j=31.
- **Busy:** `busy` is high in START and WAIT only.

## Timing
- **Reset values:**
  - state=IDLE.
  - `in_ready`, `out_valid`, `out_last`, `core_start`, `busy` = 0.
  - `out_data` = 0, `core_n` = 0, `core_q` = 0.
  - Counters = 0.
- **After reset release:** `in_ready` goes to 1 one cycle after the first rising edge (IDLE→LOAD).
- **Launch latency:** the 64th byte is accepted at edge k; `core_start` is high during cycle k+1; WAIT begins at k+2.
- **Result latency:** `core_done` is sampled at edge d; `out_valid=1` with byte 0 from d+1.
- **Output backpressure:**
  - `out_data`, `out_valid` and `out_last` are all registered.
  - They are held stable while `out_valid && !out_ready`.
- **Output throughput:** with `out_ready` held high, the block emits one byte per cycle: 32 cycles.
- **Turnaround:** the last byte is accepted at edge e; `in_ready=1` from e+1. There is no input acceptance during START, WAIT or SEND.
- **Input gaps:** gaps in `in_valid` stall the counter without losing data.
- **Reset mid-operation:**
  - All state is abandoned immediately.
  - A core still running may later pulse `core_done`; this is ignored because the block is not in WAIT.
  - The next job starts from byte 0.

## Test plan
- **Basepoint job:**
  - Stimulus: 32 bytes 0x00, then bytes 0x09 followed by 31×0x00, with `out_ready` held high.
  - Required `core_n`/`core_q`: `core_n`=0x4000…0000, `core_q`=9, `core_start` one cycle.
  - Core response: the core model returns 0x743bcb58…a37de52f.
  - Required output: 0x2f, 0xe5, 0x7d, … 0x74, with `out_last` on 0x74.
- **Clamp/mask:**
  - Stimulus: 64×0xFF.
  - Required: `core_n`=0x7FFF…FFF8 and `core_q`=0x7FFF…FFFF.
  - Repeat with CLAMP=0: `core_n`=0x7FFF…FFFF.
- **Flow control:**
  - Stimulus: `in_valid` toggled randomly during LOAD; `out_ready` low for 5 cycles at byte 10.
  - Required: identical result bytes; byte 10 held stable throughout the stall; no byte dropped or duplicated.
- **Stray done:**
  - Stimulus: pulse `core_done` with `core_out`=0x123 in LOAD and in SEND.
  - Required: no state change and no result overwrite.
- **Reset mid-job:**
  - Stimulus: assert `reset_n`=0 during WAIT, then submit the basepoint job.
  - Required: all outputs 0 during reset; the next job produces the correct basepoint result.
- **Back-to-back jobs:**
  - Stimulus: two jobs sent back to back.
  - Required: `in_ready` rises the cycle after the previous `out_last` transfer; both results are correct.

Source files
------------

// File: rtl/x25519_byte_frontend_if.sv
// Byte-stream and core-side signals of the x25519 front end.
// slave is the front end itself; master is the transport/core side driving it.
interface x25519_byte_frontend_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         core_start;
    logic [254:0] core_n;
    logic [254:0] core_q;
    logic         core_done;
    logic [254:0] core_out;
    logic         busy;

    modport slave (
        input  in_data, in_valid, out_ready, core_done, core_out,
        output in_ready, out_data, out_valid, out_last, core_start, core_n, core_q, busy
    );

    modport master (
        output in_data, in_valid, out_ready, core_done, core_out,
        input  in_ready, out_data, out_valid, out_last, core_start, core_n, core_q, busy
    );
endinterface

// File: rtl/x25519_byte_frontend.sv
// Collects a 64-byte x25519 job, clamps/masks it, launches the curve25519 core
// and streams the 32-byte little-endian result back out.
//
// state | meaning
// IDLE  | one cycle after reset before accepting bytes
// LOAD  | accepting job bytes 0..63 (scalar, then u)
// START | core_start pulse, core_n/core_q valid
// WAIT  | waiting for core_done
// SEND  | streaming result bytes 0..31
module x25519_byte_frontend #(
    parameter int CLAMP = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    x25519_byte_frontend_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        SEND
    } state_t;

    state_t        state;
    logic [5:0]    byte_cnt;
    logic [4:0]    out_cnt;
    logic [254:0]  n_buf;
    logic [247:0]  u_buf;
    logic [247:0]  res_hi;
    logic [7:0]    in_byte;

    logic          in_ready_q;
    logic [7:0]    out_data_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          core_start_q;
    logic [254:0]  core_n_q;
    logic [254:0]  core_q_q;
    logic          busy_q;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.core_start = core_start_q;
    assign bus.core_n     = core_n_q;
    assign bus.core_q     = core_q_q;
    assign bus.busy       = busy_q;

    // Clamping is folded into the byte write so the scalar buffer already holds core_n.
    always_comb begin
        in_byte = bus.in_data;
        if (CLAMP != 0 && byte_cnt == 6'd0) begin
            in_byte[2:0] = 3'b000;
        end
        if (CLAMP != 0 && byte_cnt == 6'd31) begin
            in_byte[6] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            byte_cnt     <= 6'd0;
            out_cnt      <= 5'd0;
            n_buf        <= '0;
            u_buf        <= '0;
            res_hi       <= '0;
            in_ready_q   <= 1'b0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_n_q     <= '0;
            core_q_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= LOAD;
                    in_ready_q <= 1'b1;
                end

                LOAD: begin
                    if (bus.in_valid) begin
                        if (byte_cnt == 6'd31) begin
                            n_buf[254:248] <= in_byte[6:0];
                        end else if (!byte_cnt[5]) begin
                            n_buf[{byte_cnt[4:0], 3'b000} +: 8] <= in_byte;
                        end else if (byte_cnt != 6'd63) begin
                            u_buf[{byte_cnt[4:0], 3'b000} +: 8] <= in_byte;
                        end
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt == 6'd63) begin
                            // Last u byte arrives now; bit 255 of u is dropped here.
                            state        <= START;
                            in_ready_q   <= 1'b0;
                            core_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                            core_n_q     <= n_buf;
                            core_q_q     <= {in_byte[6:0], u_buf};
                        end
                    end
                end

                START: begin
                    core_start_q <= 1'b0;
                    state        <= WAIT;
                end

                WAIT: begin
                    if (bus.core_done) begin
                        res_hi      <= {1'b0, bus.core_out[254:8]};
                        out_data_q  <= bus.core_out[7:0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_cnt     <= 5'd0;
                        busy_q      <= 1'b0;
                        state       <= SEND;
                    end
                end

                SEND: begin
                    if (bus.out_ready) begin
                        if (out_cnt == 5'd31) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            out_data_q <= res_hi[7:0];
                            res_hi     <= {8'h00, res_hi[247:8]};
                            out_cnt    <= out_cnt + 5'd1;
                            out_last_q <= (out_cnt == 5'd30);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x25519_byte_frontend.sv
// Scoreboard bench for x25519_byte_frontend: drives byte jobs, models the core,
// and compares launched operands and streamed result bytes against expectations.
module tb_x25519_byte_frontend;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic mirror = 1'b0;

    always #5 clock = ~clock;

    x25519_byte_frontend_if bus ();
    x25519_byte_frontend_if bus_nc ();

    x25519_byte_frontend #(.CLAMP(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    x25519_byte_frontend #(.CLAMP(0)) dut_nc (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_nc)
    );

    assign bus_nc.in_data   = bus.in_data;
    assign bus_nc.in_valid  = bus.in_valid & mirror;
    assign bus_nc.out_ready = 1'b1;
    assign bus_nc.core_done = 1'b0;
    assign bus_nc.core_out  = '0;

    localparam logic [254:0] BASE_RES = 255'h743bcb585f9990a1d04d4d9cf1d2d3b9f8f3e5a7c9b1d0e2f4a6c8e0a37de52f;
    localparam logic [254:0] RES2     = 255'h1f2e3d4c5b6a79880123456789abcdef00ff11ee22dd33cc44bb55aa66997788;
    localparam logic [254:0] RES3     = 255'h5555aaaa0000ffff1234fedc8765abcd0f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] K_A      = 256'hf1e2d3c4b5a69788796a5b4c3d2e1f00112233445566778899aabbccddeeff07;
    localparam logic [255:0] U_A      = 256'h80000000000000000000000000000000000000000000000000000000000000ed;
    localparam logic [255:0] K_B      = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1ff;
    localparam logic [255:0] U_B      = 256'hffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    function automatic logic [254:0] clamp_n(input logic [255:0] k);
        logic [254:0] n;
        n = k[254:0];
        n[2:0] = 3'b000;
        n[254] = 1'b1;
        return n;
    endfunction

    task automatic send_bytes(input logic [255:0] k, input logic [255:0] u, input bit gaps, input bit stray);
        int budget;
        for (int i = 0; i < 64; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
            if (i < 32) bus.in_data = k[8*i +: 8];
            else        bus.in_data = u[8*(i-32) +: 8];
            bus.in_valid = 1'b1;
            if (stray && i == 20) begin
                bus.core_done = 1'b1;
                bus.core_out  = 255'h123;
            end
            budget = 0;
            while (bus.in_ready !== 1'b1 && budget < 100) begin
                @(posedge clock);
                #1;
                budget++;
            end
            if (budget >= 100) begin
                errors++;
                $display("FAIL in_ready_timeout byte %0d: in_ready=%b, required 1", i, bus.in_ready);
            end
            @(posedge clock);
            #1;
            if (stray && i == 20) begin
                bus.core_done = 1'b0;
                bus.core_out  = '0;
                checks++;
                if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_done_load: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                             bus.in_ready, bus.out_valid, bus.busy);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_launch(input logic [254:0] en, input logic [254:0] eq);
        checks++;
        if (bus.core_start !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL launch: core_start=%b busy=%b in_ready=%b, required 1 1 0",
                     bus.core_start, bus.busy, bus.in_ready);
        end
        checks++;
        if (bus.core_n !== en) begin
            errors++;
            $display("FAIL core_n: got %h, required %h", bus.core_n, en);
        end
        checks++;
        if (bus.core_q !== eq) begin
            errors++;
            $display("FAIL core_q: got %h, required %h", bus.core_q, eq);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.core_start !== 1'b0 || bus.busy !== 1'b1 || bus.core_n !== en) begin
            errors++;
            $display("FAIL start_pulse: core_start=%b busy=%b, required 0 1 with core_n held",
                     bus.core_start, bus.busy);
        end
    endtask

    task automatic core_respond(input logic [254:0] res);
        logic [255:0] r;
        r = {1'b0, res};
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: busy=%b out_valid=%b, required 1 0", bus.busy, bus.out_valid);
        end
        for (int j = 0; j < 32; j++) begin
            exp_q.push_back({(j == 31) ? 1'b1 : 1'b0, r[8*j +: 8]});
        end
        bus.core_done = 1'b1;
        bus.core_out  = res;
        @(posedge clock);
        #1;
        bus.core_done = 1'b0;
        bus.core_out  = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL result_latency: out_valid=%b busy=%b, required 1 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic receive_result(input int stall_at, input int stray_at);
        logic [8:0] exp;
        logic [8:0] held;
        int budget;
        for (int j = 0; j < 32; j++) begin
            budget = 0;
            while (bus.out_valid !== 1'b1 && budget < 100) begin
                @(posedge clock);
                #1;
                budget++;
            end
            if (budget >= 100) begin
                errors++;
                $display("FAIL out_valid_timeout byte %0d: out_valid=%b, required 1", j, bus.out_valid);
            end
            if (j == 0) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL no_accept_in_send: in_ready=%b, required 0", bus.in_ready);
                end
            end
            if (j == stall_at) begin
                bus.out_ready = 1'b0;
                held = {bus.out_last, bus.out_data};
                repeat (5) begin
                    @(posedge clock);
                    #1;
                    checks++;
                    if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== held) begin
                        errors++;
                        $display("FAIL stall_hold byte %0d: valid=%b last/data=%h, required 1 %h",
                                 j, bus.out_valid, {bus.out_last, bus.out_data}, held);
                    end
                end
                bus.out_ready = 1'b1;
            end
            if (j == stray_at) begin
                bus.core_done = 1'b1;
                bus.core_out  = 255'h123;
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty byte %0d: got %h, required nothing", j, bus.out_data);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if ({bus.out_last, bus.out_data} !== exp) begin
                    errors++;
                    $display("FAIL out_byte %0d: last/data=%h, required %h", j, {bus.out_last, bus.out_data}, exp);
                end
            end
            @(posedge clock);
            #1;
            bus.core_done = 1'b0;
            bus.core_out  = '0;
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL turnaround: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic run_job(input logic [255:0] k, input logic [255:0] u, input logic [254:0] res,
                           input bit gaps, input int stall_at, input bit stray_load, input int stray_send);
        send_bytes(k, u, gaps, stray_load);
        check_launch(clamp_n(k), u[254:0]);
        core_respond(res);
        receive_result(stall_at, stray_send);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.core_start !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.core_n !== '0 || bus.core_q !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b ov=%b ol=%b cs=%b busy=%b od=%h, required all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.core_start, bus.busy, bus.out_data);
        end
        reset_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_basepoint();
        run_job(256'h0, 256'h9, BASE_RES, 1'b0, -1, 1'b0, -1);
    endtask

    task automatic test_clamp_mask();
        logic [254:0] ones;
        ones = '1;
        mirror = 1'b1;
        send_bytes('1, '1, 1'b0, 1'b0);
        mirror = 1'b0;
        checks++;
        if (bus_nc.core_n !== ones) begin
            errors++;
            $display("FAIL noclamp_core_n: got %h, required %h", bus_nc.core_n, ones);
        end
        checks++;
        if (bus_nc.core_q !== ones) begin
            errors++;
            $display("FAIL noclamp_core_q: got %h, required %h", bus_nc.core_q, ones);
        end
        check_launch({1'b1, {251{1'b1}}, 3'b000}, ones);
        core_respond(RES2);
        receive_result(-1, -1);
    endtask

    task automatic test_flow_control();
        run_job(256'h0, 256'h9, BASE_RES, 1'b1, 10, 1'b0, -1);
    endtask

    task automatic test_stray_done();
        run_job(K_A, U_A, RES3, 1'b0, -1, 1'b1, 5);
    endtask

    task automatic test_reset_mid_job();
        send_bytes(K_B, U_B, 1'b0, 1'b0);
        check_launch(clamp_n(K_B), U_B[254:0]);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.core_start !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.core_n !== '0 || bus.core_q !== '0) begin
            errors++;
            $display("FAIL midjob_reset_values: rdy=%b ov=%b cs=%b busy=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.core_start, bus.busy);
        end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        bus.core_done = 1'b1;
        bus.core_out  = 255'h123;
        @(posedge clock);
        #1;
        bus.core_done = 1'b0;
        bus.core_out  = '0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL late_done_after_reset: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        run_job(256'h0, 256'h9, BASE_RES, 1'b0, -1, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_job(K_A, U_B, RES2, 1'b0, -1, 1'b0, -1);
        run_job(K_B, U_A, BASE_RES, 1'b0, -1, 1'b0, -1);
    endtask

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.core_done = 1'b0;
        bus.core_out  = '0;
        test_reset();
        test_basepoint();
        test_clamp_mask();
        test_flow_control();
        test_stray_done();
        test_reset_mid_job();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d bytes remain, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
